// File: rtl/divider_unit_pkg.sv
// Shared definitions for the iterative integer divider.
//   XLEN    : operand / result width
//   STEPS   : restoring shift-subtract iterations per division
//   CNT_W   : width of the step counter
//   state_e : controller states IDLE / CALC / DONE
package divider_unit_pkg;

  localparam int XLEN  = 32;
  localparam int STEPS = XLEN;
  localparam int CNT_W = $clog2(STEPS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/divider_unit.sv
// Iterative 32-bit integer divider (DIV/DIVU/REM/REMU semantics).
// One restoring shift-subtract step per clock; start-to-done is 33 cycles,
// or 1 cycle for a zero divisor.
//   clk, rst_n        : clock, async active-low reset
//   start             : request, sampled only while idle
//   is_signed         : 1 = two's-complement, 0 = unsigned (latched with start)
//   a, b              : dividend, divisor (latched with start)
//   busy              : high while iterating
//   done              : one-cycle pulse, results valid
//   quotient,remainder: results, held until the next completion
//   div_by_zero       : zero-divisor flag for the held results
module divider_unit
  import divider_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            is_signed,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            div_by_zero
);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_rem;     // partial remainder, always < divisor
  logic [XLEN-1:0]  r_quo;     // dividend shifts out MSB-first, quotient bits shift in
  logic [XLEN-1:0]  r_dvsr;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [XLEN-1:0]  r_quotient;
  logic [XLEN-1:0]  r_remainder;
  logic             r_dbz;

  // Operand magnitudes. Negating 0x80000000 yields 0x80000000, which is the
  // correct unsigned magnitude, so the overflow case needs no special path.
  logic            w_a_neg, w_b_neg;
  logic [XLEN-1:0] w_a_mag, w_b_mag;

  assign w_a_neg = is_signed & a[XLEN-1];
  assign w_b_neg = is_signed & b[XLEN-1];
  assign w_a_mag = w_a_neg ? (~a + 1'b1) : a;
  assign w_b_mag = w_b_neg ? (~b + 1'b1) : b;

  // Restoring step on a 33-bit word: the extra bit is the borrow of the
  // trial subtraction. Borrow clear means the divisor fits -> quotient bit 1.
  logic [XLEN:0]   w_shift, w_diff;
  logic            w_qbit;
  logic [XLEN-1:0] w_rem_nx, w_quo_nx;

  assign w_shift  = {r_rem, r_quo[XLEN-1]};
  assign w_diff   = w_shift - {1'b0, r_dvsr};
  assign w_qbit   = ~w_diff[XLEN];
  assign w_rem_nx = w_qbit ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
  assign w_quo_nx = {r_quo[XLEN-2:0], w_qbit};

  // Sign fix-up applied to the final step's output so results register on
  // the same edge the FSM enters DONE.
  logic [XLEN-1:0] w_q_fix, w_r_fix;

  assign w_q_fix = r_neg_q ? (~w_quo_nx + 1'b1) : w_quo_nx;
  assign w_r_fix = r_neg_r ? (~w_rem_nx + 1'b1) : w_rem_nx;

  logic w_last;
  assign w_last = (r_cnt == CNT_W'(STEPS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvsr      <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            if (b == '0) begin
              // Zero divisor short-circuits straight to DONE.
              r_state     <= DONE;
              r_quotient  <= '1;
              r_remainder <= a;
              r_dbz       <= 1'b1;
            end else begin
              r_state <= CALC;
              r_cnt   <= '0;
              r_rem   <= '0;
              r_quo   <= w_a_mag;
              r_dvsr  <= w_b_mag;
              r_neg_q <= w_a_neg ^ w_b_neg;
              r_neg_r <= w_a_neg;
            end
          end
        end
        CALC: begin
          r_rem <= w_rem_nx;
          r_quo <= w_quo_nx;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_state     <= DONE;
            r_quotient  <= w_q_fix;
            r_remainder <= w_r_fix;
            r_dbz       <= 1'b0;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy        = (r_state == CALC);
  assign done        = (r_state == DONE);
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_divider_unit.sv
// Directed-vector bench for divider_unit: the driver pushes hand-computed
// expectations into a scoreboard queue, a negedge monitor pops and compares
// whenever done pulses, and also checks outputs while reset is held.
module tb_divider_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  divider_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .is_signed  (is_signed),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;    // edges from accepting start through done, inclusive
    int          nbusy;  // cycles with busy high
    int          t0;     // cycle count at the accepting edge
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  int   n_exp = 0;
  int   n_done = 0;
  bit   fin_req = 1'b0;
  bit   fin_ack = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- monitor ----------------
  int busy_cnt = 0;
  int wait_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (fin_req && !fin_ack) begin
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      chk("done_count", 32'(n_done), 32'(n_exp));
      fin_ack = 1'b1;
    end
    if (!rst_n) begin
      chk("rst_outputs", {busy, done, div_by_zero}, 32'd0);
      chk("rst_quotient", quotient, 32'd0);
      chk("rst_remainder", remainder, 32'd0);
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        n_done++;
        if (sb.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_quotient"}, quotient, e.q);
          chk({e.name, "_remainder"}, remainder, e.r);
          chk({e.name, "_dbz"}, 32'(div_by_zero), 32'(e.dz));
          chk({e.name, "_latency"}, 32'(cyc - e.t0 + 1), 32'(e.lat));
          chk({e.name, "_busy_cycles"}, 32'(busy_cnt), 32'(e.nbusy));
        end
        busy_cnt = 0;
        wait_cnt = 0;
      end else if (sb.size() != 0) begin
        wait_cnt++;
        if (wait_cnt > 80) begin
          n_chk++;
          n_err++;
          $display("FAIL timeout_%s: got no done after %0d cycles expected done", sb[0].name, wait_cnt);
          sb.delete();
          wait_cnt = 0;
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Issues one op from a negedge; optionally pulses a spurious start with
  // other operands 'glitch' cycles after the accepting edge.
  task automatic op(input string name, input logic [31:0] ia, input logic [31:0] ib,
                    input logic s, input logic [31:0] eq, input logic [31:0] er,
                    input logic edz, input int elat, input int ebusy, input int glitch);
    exp_t e;
    e.q = eq; e.r = er; e.dz = edz; e.lat = elat; e.nbusy = ebusy;
    e.t0 = cyc + 1; e.name = name;
    sb.push_back(e);
    n_exp++;
    start = 1'b1; a = ia; b = ib; is_signed = s;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; is_signed = 1'($urandom);
    if (glitch > 0) begin
      for (int i = 1; i < glitch; i++) @(negedge clk);
      start = 1'b1; a = 32'd9; b = 32'd9; is_signed = 1'b0;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);  // DONE -> IDLE; next start lands in the IDLE cycle
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    op("u100_7",   32'd100,        32'd7,        1'b0, 32'd14,         32'd2,        1'b0, 33, 32, 0);
    op("s-7_2",    32'hFFFF_FFF9,  32'd2,        1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF, 1'b0, 33, 32, 0);
    op("s7_-2",    32'd7,          32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1,        1'b0, 33, 32, 0);
    op("s-7_-2",   32'hFFFF_FFF9,  32'hFFFF_FFFE, 1'b1, 32'd3,         32'hFFFF_FFFF, 1'b0, 33, 32, 0);
    op("u_dz",     32'd5,          32'd0,        1'b0, 32'hFFFF_FFFF,  32'd5,        1'b1, 1,  0,  0);
    op("s_dz",     32'd5,          32'd0,        1'b1, 32'hFFFF_FFFF,  32'd5,        1'b1, 1,  0,  0);
    op("s_ovf",    32'h8000_0000,  32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0,        1'b0, 33, 32, 0);
    op("u_ovfops", 32'h8000_0000,  32'hFFFF_FFFF, 1'b0, 32'd0,         32'h8000_0000, 1'b0, 33, 32, 0);
    op("u_max_1",  32'hFFFF_FFFF,  32'd1,        1'b0, 32'hFFFF_FFFF,  32'd0,        1'b0, 33, 32, 0);
    op("u0_5",     32'd0,          32'd5,        1'b0, 32'd0,          32'd0,        1'b0, 33, 32, 0);
    op("ign_start", 32'd1000,      32'd3,        1'b0, 32'd333,        32'd1,        1'b0, 33, 32, 10);

    // Abort a running op with reset 15 cycles into CALC; no done may follow.
    start = 1'b1; a = 32'd1000; b = 32'd3; is_signed = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    op("post_rst", 32'd65035,      32'd4932,     1'b0, 32'd13,         32'd919,      1'b0, 33, 32, 0);

    fin_req = 1'b1;
    for (int i = 0; i < 10 && !fin_ack; i++) @(negedge clk);
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
